// File: rtl/seq_pkg.sv
// Shared definitions for the seq_pattern_tx serial pattern transmitter:
// FSM state encoding, default "110101" pattern constants and a counter-width helper.
// The GAP state exists only when SEQ_TX_GAP_EN is defined.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef SEQ_TX_GAP_EN
    ST_GAP   = 2'd2,
`endif
    ST_FIN   = 2'd3
  } state_e;

  // Default target sequence and its longest proper prefix that is also a suffix
  localparam int         DEF_PAT_W   = 6;
  localparam logic [5:0] DEF_PATTERN = 6'b110101;
  localparam int         DEF_OVL_LEN = 1;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int cnt_w(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable PAT_W-bit word register with a bit-index counter.
// Presents one bit per cycle on a registered output, MSB first. A load starts
// at the MSB; a restart re-enters the latched word at a given index so that
// later repetitions can skip an overlapping prefix. With no command the
// output bit returns to 0.
module seq_tx_shreg
  import seq_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int IDX_W = cnt_w(DEF_PAT_W - 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_data,
  input  logic             i_restart,
  input  logic [IDX_W-1:0] i_start_idx,
  input  logic             i_step,
  output logic             o_bit,
  output logic             o_last_bit
);

  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  logic [PAT_W-1:0] r_word;
  logic [IDX_W-1:0] r_idx;
  logic             r_bit;

  // Word latch, index of the bit currently on the line, and the line bit itself
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= {PAT_W{1'b0}};
      r_idx  <= {IDX_W{1'b0}};
      r_bit  <= 1'b0;
    end else if (i_load) begin
      r_word <= i_data;
      r_idx  <= IDX_MSB;
      r_bit  <= i_data[PAT_W-1];
    end else if (i_restart) begin
      r_idx  <= i_start_idx;
      r_bit  <= r_word[i_start_idx];
    end else if (i_step) begin
      r_idx  <= r_idx - IDX_W'(1);
      r_bit  <= r_word[r_idx - IDX_W'(1)];
    end else begin
      r_bit  <= 1'b0;
    end
  end

  assign o_bit      = r_bit;
  assign o_last_bit = (r_idx == {IDX_W{1'b0}});

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: takes a word over valid/ready, shifts it out
// MSB first a programmable number of times (optionally overlapping the
// repeated prefix) and raises exp_y the cycle after each repetition's last
// bit when the word equals PATTERN, matching a Moore detector's y.
// Optional macro SEQ_TX_GAP_EN: inserts GAP_CYC zero cycles between
// repetitions and disables overlap.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               OVL_LEN = DEF_OVL_LEN,
  parameter int               CNT_W   = 4
`ifdef SEQ_TX_GAP_EN
  ,
  parameter int               GAP_CYC = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] in_data,
  input  logic [CNT_W-1:0] in_rep,
  input  logic             in_ovl,
  output logic             in_ready,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic             exp_y
);

  localparam int               IDX_W    = cnt_w(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_OVL  = IDX_W'(PAT_W - 1 - OVL_LEN);

`ifdef SEQ_TX_GAP_EN
  // The idle gap breaks any overlap, so the overlap request is dropped
  localparam logic             OVL_OK   = 1'b0;
  localparam int               GAP_W    = cnt_w(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
`else
  localparam logic             OVL_OK   = 1'b1;
`endif

  state_e           r_state;
  state_e           w_state_nxt;

  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_exp_y;
  logic [CNT_W-1:0] r_rep_lat;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_match;
  logic             r_ovl;

  logic             w_accept;
  logic             w_load;
  logic             w_restart;
  logic             w_step;
  logic             w_rep_inc;
  logic             w_ready_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_expy_nxt;
  logic             w_last_bit;
  logic             w_last_rep;
  logic             w_bit;
  logic [IDX_W-1:0] w_start_idx;
  logic [CNT_W-1:0] w_rep_eff;

`ifdef SEQ_TX_GAP_EN
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_gap_clr;
  logic             w_gap_inc;
`endif

  assign w_accept    = in_valid && r_in_ready;
  assign w_last_rep  = (r_rep_cnt == r_rep_lat);
  assign w_start_idx = r_ovl ? IDX_OVL : IDX_FULL;
  assign w_rep_eff   = (in_rep == {CNT_W{1'b0}}) ? CNT_W'(1) : in_rep;

  seq_tx_shreg #(
    .PAT_W (PAT_W),
    .IDX_W (IDX_W)
  ) u_shreg (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_data      (in_data),
    .i_restart   (w_restart),
    .i_start_idx (w_start_idx),
    .i_step      (w_step),
    .o_bit       (w_bit),
    .o_last_bit  (w_last_bit)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, shift-register commands and next values of the registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_restart   = 1'b0;
    w_step      = 1'b0;
    w_rep_inc   = 1'b0;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_expy_nxt  = 1'b0;
`ifdef SEQ_TX_GAP_EN
    w_gap_clr   = 1'b0;
    w_gap_inc   = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_busy_nxt = 1'b1;
        if (w_last_bit) begin
          // The completing bit is on the line now; a Moore detector answers next cycle
          w_expy_nxt = r_match;
          if (w_last_rep) begin
            w_state_nxt = ST_FIN;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_ready_nxt = 1'b1;
          end else begin
            w_rep_inc = 1'b1;
`ifdef SEQ_TX_GAP_EN
            if (GAP_CYC > 0) begin
              w_state_nxt = ST_GAP;
              w_gap_clr   = 1'b1;
            end else begin
              w_restart = 1'b1;
            end
`else
            w_restart = 1'b1;
`endif
          end
        end else begin
          w_step = 1'b1;
        end
      end
`ifdef SEQ_TX_GAP_EN
      ST_GAP: begin
        w_busy_nxt = 1'b1;
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_SHIFT;
          w_restart   = 1'b1;
        end else begin
          w_gap_inc = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // Registered handshake/status outputs and the per-word latched context
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_exp_y    <= 1'b0;
      r_rep_lat  <= {CNT_W{1'b0}};
      r_rep_cnt  <= {CNT_W{1'b0}};
      r_match    <= 1'b0;
      r_ovl      <= 1'b0;
    end else begin
      r_in_ready <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_exp_y    <= w_expy_nxt;
      if (w_load) begin
        r_rep_lat <= w_rep_eff;
        r_rep_cnt <= CNT_W'(1);
        r_match   <= (in_data == PATTERN);
        r_ovl     <= in_ovl & OVL_OK;
      end else if (w_rep_inc && (r_rep_cnt != r_rep_lat)) begin
        // Saturates at the latched count, never wraps
        r_rep_cnt <= r_rep_cnt + CNT_W'(1);
      end else begin
        r_rep_cnt <= r_rep_cnt;
      end
    end
  end

`ifdef SEQ_TX_GAP_EN
  // Counts idle cycles spent between repetitions
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap_cnt <= {GAP_W{1'b0}};
    end else if (w_gap_clr) begin
      r_gap_cnt <= {GAP_W{1'b0}};
    end else if (w_gap_inc) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end else begin
      r_gap_cnt <= r_gap_cnt;
    end
  end
`endif

  assign in_ready = r_in_ready;
  assign x        = w_bit;
  assign busy     = r_busy;
  assign done     = r_done;
  assign exp_y    = r_exp_y;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx. A per-cycle expected-output list is
// built from the transmit rules for each word, a reference Moore "110101"
// detector watches x, and one process compares every cycle.
module tb_seq_pattern_tx;

  localparam int         PAT_W   = 6;
  localparam int         OVL_LEN = 1;
  localparam int         GAP_CYC = 2;
  localparam logic [5:0] PATTERN = 6'b110101;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [5:0] in_data;
  logic [3:0] in_rep;
  logic       in_ovl;
  logic       in_ready;
  logic       x;
  logic       busy;
  logic       done;
  logic       exp_y;

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_rep   (in_rep),
    .in_ovl   (in_ovl),
    .in_ready (in_ready),
    .x        (x),
    .busy     (busy),
    .done     (done),
    .exp_y    (exp_y)
  );

  typedef struct packed {
    logic x;
    logic busy;
    logic done;
    logic ey;
    logic ready;
  } rec_t;

  localparam rec_t IDLE_REC = '{x: 1'b0, busy: 1'b0, done: 1'b0, ey: 1'b0, ready: 1'b1};

  rec_t exp_q[$];
  rec_t last_recs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference Moore detector: y is high the cycle after the completing bit
  logic [5:0] hist;
  logic       det_y;
  always @(posedge clk) begin
    if (reset) hist <= 6'b000000;
    else       hist <= {hist[4:0], x};
  end
  assign det_y = (hist == PATTERN);

  task automatic chk(input string name, input logic act, input logic want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, want);
    end
  endtask

  task automatic pin(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Expected cycle-by-cycle outputs for one accepted word
  function automatic void build(input logic [5:0] w, input int rep, input logic ovl);
    int   reps;
    int   span;
    int   ends[$];
    logic ovl_eff;
    rec_t rc;
    reps = (rep == 0) ? 1 : rep;
`ifdef SEQ_TX_GAP_EN
    ovl_eff = 1'b0;
`else
    ovl_eff = ovl;
`endif
    span = PAT_W - (ovl_eff ? OVL_LEN : 0);
    last_recs.delete();
    for (int r = 0; r < reps; r++) begin
      int n;
      n = (r == 0) ? PAT_W : span;
      for (int j = n - 1; j >= 0; j--) begin
        rc = '{x: w[j], busy: 1'b1, done: 1'b0, ey: 1'b0, ready: 1'b0};
        last_recs.push_back(rc);
      end
      ends.push_back(last_recs.size());
`ifdef SEQ_TX_GAP_EN
      if (r != reps - 1) begin
        for (int g = 0; g < GAP_CYC; g++) begin
          rc = '{x: 1'b0, busy: 1'b1, done: 1'b0, ey: 1'b0, ready: 1'b0};
          last_recs.push_back(rc);
        end
      end
`endif
    end
    rc = '{x: 1'b0, busy: 1'b0, done: 1'b1, ey: 1'b0, ready: 1'b1};
    last_recs.push_back(rc);
    foreach (ends[i]) begin
      rc = last_recs[ends[i]];
      rc.ey = (w == PATTERN);
      last_recs[ends[i]] = rc;
    end
  endfunction

  function automatic int xs_of();
    int v;
    v = 0;
    foreach (last_recs[i]) if (last_recs[i].busy) v = (v << 1) | int'(last_recs[i].x);
    return v;
  endfunction

  function automatic int ey_count();
    int c;
    c = 0;
    foreach (last_recs[i]) c += int'(last_recs[i].ey);
    return c;
  endfunction

  // Called at a falling edge: offers one word for one cycle and queues its expectations
  task automatic send(input logic [5:0] w, input int rep, input logic ovl);
    build(w, rep, ovl);
    in_valid = 1'b1;
    in_data  = w;
    in_rep   = rep[3:0];
    in_ovl   = ovl;
    foreach (last_recs[i]) exp_q.push_back(last_recs[i]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Compare process: one check set per cycle, just after the active edge
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = IDLE_REC;
      chk("x", x, e.x);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("exp_y", exp_y, e.ey);
      chk("in_ready", in_ready, e.ready);
      chk("detector_y", exp_y, det_y);
    end
  end

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 6'b000000;
    in_rep   = 4'd0;
    in_ovl   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame
    send(6'b110101, 1, 1'b0);
    pin("t1_len", last_recs.size(), 7);
    pin("t1_bits", xs_of(), 32'b110101);
    pin("t1_ey_c7", int'(last_recs[6].ey), 1);
    pin("t1_done_c7", int'(last_recs[6].done), 1);
    repeat (8) @(negedge clk);

    // Two repetitions with overlap
    send(6'b110101, 2, 1'b1);
`ifdef SEQ_TX_GAP_EN
    pin("t2_len", last_recs.size(), 15);
    pin("t2_bits", xs_of(), 32'b11010100110101);
    pin("t2_ey_c15", int'(last_recs[14].ey), 1);
`else
    pin("t2_len", last_recs.size(), 12);
    pin("t2_bits", xs_of(), 32'b11010110101);
    pin("t2_ey_c12", int'(last_recs[11].ey), 1);
`endif
    pin("t2_ey_c7", int'(last_recs[6].ey), 1);
    n = last_recs.size();
    repeat (n + 1) @(negedge clk);

    // Two repetitions, no overlap
    send(6'b110101, 2, 1'b0);
`ifdef SEQ_TX_GAP_EN
    pin("t3_len", last_recs.size(), 15);
`else
    pin("t3_len", last_recs.size(), 13);
    pin("t3_bits", xs_of(), 32'b110101110101);
    pin("t3_ey_c13", int'(last_recs[12].ey), 1);
`endif
    n = last_recs.size();
    repeat (n + 1) @(negedge clk);

    // Non-matching word, three repetitions
    send(6'b101010, 3, 1'b0);
`ifdef SEQ_TX_GAP_EN
    pin("t4_len", last_recs.size(), 23);
`else
    pin("t4_len", last_recs.size(), 19);
    pin("t4_done_c19", int'(last_recs[18].done), 1);
`endif
    pin("t4_ey_none", ey_count(), 0);
    n = last_recs.size();
    repeat (n + 1) @(negedge clk);

    // Repetition count 0 behaves as 1
    send(6'b110101, 0, 1'b1);
    pin("t5_len", last_recs.size(), 7);
    repeat (8) @(negedge clk);

    // New word accepted during the FIN cycle
    send(6'b110101, 1, 1'b0);
    repeat (6) @(negedge clk);
    send(6'b101010, 1, 1'b1);
    repeat (9) @(negedge clk);

    // Word offered while busy is ignored; reset mid-transfer aborts with no done
    send(6'b110101, 2, 1'b1);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 6'b011011;
    in_rep   = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Recovery after reset: three overlapping repetitions
    send(6'b110101, 3, 1'b1);
`ifndef SEQ_TX_GAP_EN
    pin("t8_len", last_recs.size(), 17);
`endif
    pin("t8_ey_cnt", ey_count(), 3);
    n = last_recs.size();
    repeat (n + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It is the drive side for the team's Moore "110101" overlapping sequence detectors.
- Accepts a parallel word through a valid/ready handshake and shifts it out MSB-first on a 1-bit line, one bit per clock.
- Repeats the word a programmable number of times, optionally overlapping the repeated prefix.
- Produces a golden expected-detection flag aligned to a Moore detector's y output.
- Used as stimulus source and self-check reference in detector benches and the mini-project top.

Parameters:
PAT_W, 6, pattern/word width in bits
PATTERN, 6'b110101, target sequence used to compute exp_y
OVL_LEN, 1, overlap length (length of PATTERN's longest proper prefix that is also a suffix), range 0..PAT_W-1
CNT_W, 4, width of repetition count
GAP_CYC, 2, idle zero bits between repetitions (only with SEQ_TX_GAP_EN)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
in_valid  in  1  word offered
in_data  in  PAT_W  word to transmit, MSB first
in_rep  in  CNT_W  repetition count, sampled with word; 0 treated as 1
in_ovl  in  1  overlap mode, sampled with word
in_ready  out  1  block can accept a word
x  out  1  serial output bit (drives detector x)
busy  out  1  transmission in progress
done  out  1  one-cycle pulse after final bit
exp_y  out  1  expected Moore detector y

Behaviour:
- Reset (clk edge with reset=1): x=0, in_ready=1, busy=0, done=0, exp_y=0, FSM=IDLE, all counters cleared.
- Reset during a transfer aborts it. Outputs take reset values on that edge and no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, SHIFT, GAP (GAP exists only under the macro), FIN.
- Accept occurs at an edge where in_valid && in_ready. The word, rep (0→1) and ovl are latched there; no other in_data changes are sampled.
- IDLE→SHIFT on accept. In cycle 1 after accept, x=in_data[PAT_W-1], busy=1, in_ready=0. Cycle k presents bit PAT_W-k.
- Repetition 1 always sends all PAT_W bits.
- Repetitions 2..R: with ovl=1 and OVL_LEN>0, start at bit index PAT_W-1-OVL_LEN; otherwise send the full word.
- Total bits: PAT_W + (R-1)*(PAT_W - ovl*OVL_LEN).
- SHIFT holds back-to-back bits across repetitions, with no idle cycle.
- After the last bit of repetition R, go to FIN for one cycle: x=0, done=1, busy=0, in_ready=1. Then IDLE.
- A new accept in the FIN cycle is legal: first bit appears the next cycle.
- in_valid while busy: ignored, no latching, in_ready stays 0.
- exp_y: 1 for exactly one cycle, in the cycle after the last bit of a repetition is on x, iff the latched word == PATTERN.
  - This matches Moore y, which is high the cycle after the completing bit is sampled.
  - It can coincide with done or with the first bit of the next repetition.
- The repetition counter saturates at the latched value; there is no wrap-around.

Optional Feature:
SEQ_TX_GAP_EN
- Defined: between repetitions, insert GAP_CYC cycles in GAP state with x=0, busy=1. in_ovl is ignored (treated as 0) because the gap breaks overlap. exp_y timing is unchanged relative to each repetition's last bit, and it lands in the first gap cycle.
- Undefined: the GAP state and its counter are not compiled; repetitions are back-to-back.

Decomposition:
- Package seq_pkg: FSM state enum/localparams (IDLE, SHIFT, GAP, FIN), default PATTERN and OVL_LEN constants for 110101, and the count-width helper.
- One sub-module, seq_tx_shreg: loadable PAT_W shift register with start-index load (full or offset) and a bit-index counter reporting last_bit.
- FSM, repetition counter and exp_y logic live in seq_pattern_tx.

Test Plan:
- Single frame: in_data=110101, rep=1, ovl=0.
  - x = 1,1,0,1,0,1 in cycles 1..6 after accept.
  - exp_y=1 and done=1 in cycle 7; in_ready=1 in cycle 7.
- Overlap: 110101, rep=2, ovl=1.
  - x = 1,1,0,1,0,1,1,0,1,0,1 (11 bits).
  - exp_y in cycles 7 and 12; done in cycle 12.
  - A connected detector's y matches exp_y every cycle.
- No overlap: 110101, rep=2, ovl=0.
  - 12 bits (word twice); exp_y in cycles 7 and 13.
- Non-match: in_data=101010, rep=3.
  - 18 bits sent; exp_y never asserts; done in cycle 19.
- Busy/reset:
  - in_valid with a new word during cycle 3 → ignored, output unchanged.
  - reset in cycle 4 → next cycle x=0, busy=0, in_ready=1, no done.
- SEQ_TX_GAP_EN, GAP_CYC=2, 110101, rep=2, ovl=1.
  - x = word, 0,0, word (14 cycles).
  - exp_y in cycles 7 and 15; done in cycle 15.
